// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like bus.
// Data has priority; an owner FIFO routes each response back in order.
module sram_req_arbiter #(
    parameter int OT_DEPTH = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        ot_full,
    output logic        err_stray_ok
);

    localparam int PTR_W = $clog2(OT_DEPTH);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t state, state_nxt;
    logic lock_owner, lock_owner_nxt;
    logic owner, owner_req;

    logic [OT_DEPTH-1:0] fifo;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic push, pop, head;

    // owner: 0 = inst, 1 = data
    always_comb begin
        owner = data_req;
        if (state == LOCK) owner = lock_owner;
        owner_req = owner ? data_req : inst_req;
    end

    // Gating by the registered count keeps mem_data_ok off the mem_req path
    assign ot_full = (count == CNT_W'(OT_DEPTH));
    assign mem_req = resetn & owner_req & ~ot_full;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_wr    = owner ? data_wr    : inst_wr;
            mem_size  = owner ? data_size  : inst_size;
            mem_wstrb = owner ? data_wstrb : inst_wstrb;
            mem_addr  = owner ? data_addr  : inst_addr;
            mem_wdata = owner ? data_wdata : inst_wdata;
        end
    end

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & (count != '0);
    assign head = fifo[rd_ptr];

    assign inst_addr_ok = push & ~owner;
    assign data_addr_ok = push & owner;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        state_nxt      = state;
        lock_owner_nxt = lock_owner;
        case (state)
            IDLE: begin
                if (mem_req & ~mem_addr_ok) begin
                    state_nxt      = LOCK;
                    lock_owner_nxt = owner;
                end
            end
            LOCK: begin
                if (push) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            lock_owner <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_owner <= lock_owner_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_stray_ok <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= owner;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mem_data_ok && count == '0) err_stray_ok <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with hand-computed expectations.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        ot_full, err_stray_ok;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OT_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata),
        .ot_full(ot_full), .err_stray_ok(err_stray_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    // inputs change just after the rising edge, checks on the falling edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // one response cycle: expect routing to inst (0) or data (1)
    task automatic rsp(input string tag, input logic [31:0] rd,
                       input logic who);
        cyc(); clr();
        mem_data_ok = 1; mem_rdata = rd;
        mid();
        chk({tag, "_inst_ok"}, inst_data_ok, !who);
        chk({tag, "_data_ok"}, data_data_ok, who);
        chk({tag, "_rdata"}, who ? data_rdata : inst_rdata, rd);
    endtask

    logic exp_own [4];

    initial begin
        clr();
        resetn = 0;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_full", ot_full, 0);
        chk("rst_stray", err_stray_ok, 0);
        chk("rst_cnt", dut.count, 0);
        cyc(); cyc();
        resetn = 1;

        // single inst read
        cyc(); clr();
        inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
        mid();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h1C00_0000);
        chk("t1_inst_aok", inst_addr_ok, 1);
        chk("t1_data_aok", data_addr_ok, 0);
        cyc(); clr();
        mid();
        chk("t1_cnt1", dut.count, 1);
        chk("t1_req_off", mem_req, 0);
        rsp("t1_rsp", 32'h0280_0C0C, 0);
        cyc(); clr();
        mid();
        chk("t1_cnt0", dut.count, 0);

        // priority and lock
        cyc(); clr();
        inst_req = 1; inst_addr = 32'h100;
        data_req = 1; data_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t2_prio_addr", mem_addr, 32'h200);
            chk("t2_no_aok", inst_addr_ok | data_addr_ok, 0);
            cyc();
        end
        inst_req = 0;
        mid();
        chk("t2_drop_addr", mem_addr, 32'h200);
        cyc();
        inst_req = 1; mem_addr_ok = 1;
        mid();
        chk("t2_lock_addr", mem_addr, 32'h200);
        chk("t2_data_aok", data_addr_ok, 1);
        chk("t2_inst_aok0", inst_addr_ok, 0);
        cyc();
        data_req = 0;
        mid();
        chk("t2_inst_addr", mem_addr, 32'h100);
        chk("t2_inst_aok", inst_addr_ok, 1);
        rsp("t2_r0", 32'hD0, 1);
        rsp("t2_r1", 32'hC0, 0);

        // ordering inst, data, inst
        cyc(); clr();
        inst_req = 1; mem_addr_ok = 1;
        mid(); chk("t3_aok0", inst_addr_ok, 1);
        cyc(); inst_req = 0; data_req = 1;
        mid(); chk("t3_aok1", data_addr_ok, 1);
        cyc(); data_req = 0; inst_req = 1;
        mid(); chk("t3_aok2", inst_addr_ok, 1);
        cyc(); clr();
        mid(); chk("t3_cnt3", dut.count, 3);
        rsp("t3_r0", 32'h11, 0);
        rsp("t3_r1", 32'h22, 1);
        rsp("t3_r2", 32'h33, 0);

        // fill to OT_DEPTH, then free one slot
        exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0; exp_own[3] = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(); clr();
            mem_addr_ok = 1;
            if (exp_own[i]) data_req = 1;
            else inst_req = 1;
            mid();
            chk("t4_fill_req", mem_req, 1);
        end
        cyc(); clr();
        inst_req = 1; mem_addr_ok = 1;
        mid();
        chk("t4_full", ot_full, 1);
        chk("t4_req_gated", mem_req, 0);
        chk("t4_aok_gated", inst_addr_ok, 0);
        cyc();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hA1;
        mid();
        chk("t4_pop_inst", inst_data_ok, 1);
        chk("t4_req_still0", mem_req, 0);
        cyc();
        mem_data_ok = 0; mem_addr_ok = 1;
        mid();
        chk("t4_req_again", mem_req, 1);
        chk("t4_5th_aok", inst_addr_ok, 1);
        chk("t4_not_full", ot_full, 0);
        rsp("t4_r1", 32'hA2, 1);
        rsp("t4_r2", 32'hA3, 0);
        rsp("t4_r3", 32'hA4, 1);
        rsp("t4_r4", 32'hA5, 0);

        // simultaneous push and pop at count 2
        cyc(); clr();
        inst_req = 1; mem_addr_ok = 1;
        cyc(); inst_req = 0; data_req = 1;
        cyc(); data_req = 0; inst_req = 1;
        mem_data_ok = 1; mem_rdata = 32'h55;
        mid();
        chk("t5_pop_inst", inst_data_ok, 1);
        chk("t5_push_aok", inst_addr_ok, 1);
        cyc(); clr();
        mid();
        chk("t5_cnt2", dut.count, 2);
        rsp("t5_r0", 32'h66, 1);
        rsp("t5_r1", 32'h77, 0);

        // stray response
        cyc(); clr();
        mid();
        chk("t6_cnt0", dut.count, 0);
        chk("t6_stray_pre", err_stray_ok, 0);
        cyc();
        mem_data_ok = 1; mem_rdata = 32'hEE;
        mid();
        chk("t6_no_ok", inst_data_ok | data_data_ok, 0);
        cyc(); clr();
        mid();
        chk("t6_stray", err_stray_ok, 1);
        chk("t6_cnt_still0", dut.count, 0);
        cyc();
        mid();
        chk("t6_sticky", err_stray_ok, 1);

        // reset while locked with 2 outstanding
        cyc(); clr();
        inst_req = 1; mem_addr_ok = 1;
        cyc(); inst_req = 0; data_req = 1;
        cyc(); mem_addr_ok = 0; data_addr = 32'h300;
        cyc(); inst_req = 1; inst_addr = 32'h400;
        mid();
        chk("t7_locked", mem_addr, 32'h300);
        chk("t7_cnt2", dut.count, 2);
        #1 resetn = 0;
        #1;
        chk("t7_rst_req", mem_req, 0);
        chk("t7_rst_cnt", dut.count, 0);
        chk("t7_rst_stray", err_stray_ok, 0);
        chk("t7_rst_aok", inst_addr_ok | data_addr_ok, 0);
        cyc(); clr();
        resetn = 1;
        cyc();
        inst_req = 1; inst_addr = 32'h400; mem_addr_ok = 1;
        mid();
        chk("t7_idle_addr", mem_addr, 32'h400);
        chk("t7_idle_aok", inst_addr_ok, 1);
        cyc(); clr();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
